// File: rtl/branch_resolve_unit_if.sv
// Bus bundle between the branch resolve unit and its neighbours: branch
// descriptor + comparator flags in, resolution / redirect / statistics out.
interface branch_resolve_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned CNT_W  = 32
);
  // Branch descriptor handshake
  logic              br_valid;
  logic              br_ready;
  logic [2:0]        br_op;
  logic [ADDR_W-1:0] br_pc;
  logic [IMM_W-1:0]  br_imm;
  logic              br_pred_taken;

  // Comparator flags, sampled together with the descriptor
  logic              cmp_equal;
  logic              cmp_lower;
  logic              cmp_greater;

  // Resolution results
  logic              res_valid;
  logic              res_taken;
  logic              res_mispredict;
  logic              flag_error;
  logic              flush;

  // Redirect handshake towards fetch
  logic              redir_valid;
  logic              redir_ready;
  logic [ADDR_W-1:0] redir_pc;

  // Statistics
  logic              clr_stats;
  logic [CNT_W-1:0]  cnt_branches;
  logic [CNT_W-1:0]  cnt_taken;
  logic [CNT_W-1:0]  cnt_mispredict;

  modport master (
    output br_valid, br_op, br_pc, br_imm, br_pred_taken,
    output cmp_equal, cmp_lower, cmp_greater,
    output redir_ready, clr_stats,
    input  br_ready, res_valid, res_taken, res_mispredict, flag_error, flush,
    input  redir_valid, redir_pc,
    input  cnt_branches, cnt_taken, cnt_mispredict
  );

  modport slave (
    input  br_valid, br_op, br_pc, br_imm, br_pred_taken,
    input  cmp_equal, cmp_lower, cmp_greater,
    input  redir_ready, clr_stats,
    output br_ready, res_valid, res_taken, res_mispredict, flag_error, flush,
    output redir_valid, redir_pc,
    output cnt_branches, cnt_taken, cnt_mispredict
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves branch direction from comparator flags, checks the fetch prediction,
// issues a held redirect plus flush pulse on mispredict and keeps statistics.
module branch_resolve_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus
);

  localparam int unsigned EXT_W = ADDR_W - IMM_W;

  typedef enum logic [2:0] {
    OP_BEQ = 3'd0,
    OP_BNE = 3'd1,
    OP_BLT = 3'd2,
    OP_BGE = 3'd3,
    OP_BGT = 3'd4,
    OP_BLE = 3'd5,
    OP_JMP = 3'd6,
    OP_RSV = 3'd7
  } br_op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RESOLVE  = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [IMM_W-1:0]  imm;
    logic              flags_bad;
  } desc_t;

  state_e            state_q;
  desc_t             desc_q;
  logic              br_ready_q;
  logic              res_valid_q;
  logic              res_taken_q;
  logic              res_mispredict_q;
  logic              flush_q;
  logic              redir_valid_q;
  logic [ADDR_W-1:0] redir_pc_q;
  logic              flag_error_q, flag_error_d;
  logic [CNT_W-1:0]  cnt_branches_q, cnt_branches_d;
  logic [CNT_W-1:0]  cnt_taken_q, cnt_taken_d;
  logic [CNT_W-1:0]  cnt_mispredict_q, cnt_mispredict_d;

  logic              onehot_c;
  logic              taken_c;
  logic              mispredict_c;
  logic [ADDR_W-1:0] imm_ext_c;
  logic [ADDR_W-1:0] fallthrough_c;
  logic [ADDR_W-1:0] target_c;
  logic              in_resolve_c;

  // Direction of the incoming descriptor; resolved at the handshake so the
  // result registers are already valid during the RESOLVE cycle.
  always_comb begin
    onehot_c = (bus.cmp_equal   & ~bus.cmp_lower & ~bus.cmp_greater) |
               (~bus.cmp_equal &  bus.cmp_lower & ~bus.cmp_greater) |
               (~bus.cmp_equal & ~bus.cmp_lower &  bus.cmp_greater);
    taken_c  = 1'b0;
    case (br_op_e'(bus.br_op))
      OP_BEQ:  taken_c = onehot_c &  bus.cmp_equal;
      OP_BNE:  taken_c = onehot_c & ~bus.cmp_equal;
      OP_BLT:  taken_c = onehot_c &  bus.cmp_lower;
      OP_BGE:  taken_c = onehot_c & ~bus.cmp_lower;
      OP_BGT:  taken_c = onehot_c &  bus.cmp_greater;
      OP_BLE:  taken_c = onehot_c & ~bus.cmp_greater;
      OP_JMP:  taken_c = 1'b1;
      OP_RSV:  taken_c = 1'b0;
      default: taken_c = 1'b0;
    endcase
    mispredict_c = taken_c ^ bus.br_pred_taken;
  end

  // Target / fallthrough from the registered descriptor, modulo 2^ADDR_W
  always_comb begin
    imm_ext_c     = {{EXT_W{desc_q.imm[IMM_W-1]}}, desc_q.imm};
    fallthrough_c = desc_q.pc + ADDR_W'(4);
    target_c      = fallthrough_c + (imm_ext_c << 2);
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      desc_q           <= '0;
      br_ready_q       <= 1'b1;
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      flush_q          <= 1'b0;
      redir_valid_q    <= 1'b0;
      redir_pc_q       <= '0;
    end else begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      flush_q          <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.br_valid) begin
            desc_q.pc        <= bus.br_pc;
            desc_q.imm       <= bus.br_imm;
            desc_q.flags_bad <= ~onehot_c;
            res_valid_q      <= 1'b1;
            res_taken_q      <= taken_c;
            res_mispredict_q <= mispredict_c;
            flush_q          <= mispredict_c;
            br_ready_q       <= 1'b0;
            state_q          <= S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          if (res_mispredict_q) begin
            redir_valid_q <= 1'b1;
            redir_pc_q    <= res_taken_q ? target_c : fallthrough_c;
            state_q       <= S_REDIRECT;
          end else begin
            br_ready_q    <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        S_REDIRECT: begin
          if (bus.redir_ready) begin
            redir_valid_q <= 1'b0;
            br_ready_q    <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          redir_valid_q <= 1'b0;
          br_ready_q    <= 1'b1;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating statistics; a same-cycle clear overrides any increment
  always_comb begin
    in_resolve_c     = (state_q == S_RESOLVE);
    cnt_branches_d   = cnt_branches_q;
    cnt_taken_d      = cnt_taken_q;
    cnt_mispredict_d = cnt_mispredict_q;
    flag_error_d     = flag_error_q;
    if (bus.clr_stats) begin
      cnt_branches_d   = '0;
      cnt_taken_d      = '0;
      cnt_mispredict_d = '0;
      flag_error_d     = 1'b0;
    end else if (in_resolve_c) begin
      if (cnt_branches_q != {CNT_W{1'b1}})
        cnt_branches_d = cnt_branches_q + CNT_W'(1);
      if (res_taken_q && (cnt_taken_q != {CNT_W{1'b1}}))
        cnt_taken_d = cnt_taken_q + CNT_W'(1);
      if (res_mispredict_q && (cnt_mispredict_q != {CNT_W{1'b1}}))
        cnt_mispredict_d = cnt_mispredict_q + CNT_W'(1);
      if (desc_q.flags_bad)
        flag_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_branches_q   <= '0;
      cnt_taken_q      <= '0;
      cnt_mispredict_q <= '0;
      flag_error_q     <= 1'b0;
    end else begin
      cnt_branches_q   <= cnt_branches_d;
      cnt_taken_q      <= cnt_taken_d;
      cnt_mispredict_q <= cnt_mispredict_d;
      flag_error_q     <= flag_error_d;
    end
  end

  assign bus.br_ready       = br_ready_q;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_taken      = res_taken_q;
  assign bus.res_mispredict = res_mispredict_q;
  assign bus.flush          = flush_q;
  assign bus.redir_valid    = redir_valid_q;
  assign bus.redir_pc       = redir_pc_q;
  assign bus.flag_error     = flag_error_q;
  assign bus.cnt_branches   = cnt_branches_q;
  assign bus.cnt_taken      = cnt_taken_q;
  assign bus.cnt_mispredict = cnt_mispredict_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: a default build and a 4-bit-counter build
// share one stimulus stream and are checked against a behavioural model.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if ia ();
  branch_resolve_unit_if #(.CNT_W(4)) ib ();

  branch_resolve_unit u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  branch_resolve_unit #(.CNT_W(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  assign ib.br_valid      = ia.br_valid;
  assign ib.br_op         = ia.br_op;
  assign ib.br_pc         = ia.br_pc;
  assign ib.br_imm        = ia.br_imm;
  assign ib.br_pred_taken = ia.br_pred_taken;
  assign ib.cmp_equal     = ia.cmp_equal;
  assign ib.cmp_lower     = ia.cmp_lower;
  assign ib.cmp_greater   = ia.cmp_greater;
  assign ib.redir_ready   = ia.redir_ready;
  assign ib.clr_stats     = ia.clr_stats;

  int ncmp = 0;
  int nfail = 0;

  // Reference model state: plain running totals, saturation applied on compare
  longint m_br, m_tk, m_mis;
  bit     m_ferr;

  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam longint MAX4  = 64'd15;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sat(input longint n, input longint mx);
    return (n > mx) ? mx : n;
  endfunction

  function automatic bit m_onehot(input bit e, input bit l, input bit g);
    return (int'(e) + int'(l) + int'(g)) == 1;
  endfunction

  function automatic bit m_taken(input int op, input bit e, input bit l, input bit g);
    if (op == 6) return 1'b1;
    if (op == 7) return 1'b0;
    if (!m_onehot(e, l, g)) return 1'b0;
    case (op)
      0: return e;
      1: return !e;
      2: return l;
      3: return !l;
      4: return g;
      default: return !g;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc, input logic [15:0] imm);
    int off;
    off = 4 + 4 * int'($signed(imm));
    return pc + 32'(off);
  endfunction

  function automatic void m_clear();
    m_br = 0; m_tk = 0; m_mis = 0; m_ferr = 1'b0;
  endfunction

  // Drives one descriptor through the full resolution / redirect sequence
  task automatic run_branch(input logic [2:0] op, input logic [31:0] pc, input logic [15:0] imm,
                            input logic pred, input logic e, input logic l, input logic g,
                            input int hold, input bit clr_in_res);
    logic tk, mis;
    logic [31:0] exp_pc;
    logic [31:0] act [8];
    logic [31:0] exp [8];
    tk     = m_taken(int'(op), e, l, g);
    mis    = (tk != pred);
    exp_pc = tk ? m_target(pc, imm) : pc + 32'd4;

    ncmp++;
    if (ia.br_ready !== 1'b1) begin
      $display("FAIL br_ready_idle got %b want 1", ia.br_ready); nfail++;
    end
    ia.br_valid = 1'b1; ia.br_op = op; ia.br_pc = pc; ia.br_imm = imm;
    ia.br_pred_taken = pred; ia.cmp_equal = e; ia.cmp_lower = l; ia.cmp_greater = g;
    tick();
    ia.br_valid = 1'b0;

    ncmp++;
    if ({ia.res_valid, ia.res_taken, ia.res_mispredict, ia.flush, ia.br_ready} !==
        {1'b1, tk, mis, mis, 1'b0}) begin
      $display("FAIL resolve op=%0d pc=%h got v/t/m/f/rdy=%b%b%b%b%b want 1%b%b%b0", op, pc,
               ia.res_valid, ia.res_taken, ia.res_mispredict, ia.flush, ia.br_ready, tk, mis, mis);
      nfail++;
    end
    if (clr_in_res) ia.clr_stats = 1'b1;
    tick();
    ia.clr_stats = 1'b0;

    if (clr_in_res) m_clear();
    else begin
      m_br++;
      if (tk) m_tk++;
      if (mis) m_mis++;
      if (!m_onehot(e, l, g)) m_ferr = 1'b1;
    end
    act[0] = ia.cnt_branches;   exp[0] = 32'(sat(m_br, MAX32));
    act[1] = ia.cnt_taken;      exp[1] = 32'(sat(m_tk, MAX32));
    act[2] = ia.cnt_mispredict; exp[2] = 32'(sat(m_mis, MAX32));
    act[3] = 32'(ib.cnt_branches);   exp[3] = 32'(sat(m_br, MAX4));
    act[4] = 32'(ib.cnt_taken);      exp[4] = 32'(sat(m_tk, MAX4));
    act[5] = 32'(ib.cnt_mispredict); exp[5] = 32'(sat(m_mis, MAX4));
    act[6] = 32'(ia.flag_error);     exp[6] = 32'(m_ferr);
    act[7] = 32'(ib.flag_error);     exp[7] = 32'(m_ferr);
    for (int i = 0; i < 8; i++) begin
      ncmp++;
      if (act[i] !== exp[i]) begin
        $display("FAIL stats[%0d] got %h want %h", i, act[i], exp[i]); nfail++;
      end
    end

    ncmp++;
    if ({ia.res_valid, ia.res_taken, ia.res_mispredict, ia.flush} !== 4'b0000) begin
      $display("FAIL pulse_end got v/t/m/f=%b%b%b%b want 0000",
               ia.res_valid, ia.res_taken, ia.res_mispredict, ia.flush);
      nfail++;
    end

    if (mis) begin
      for (int c = 0; c <= hold; c++) begin
        ncmp++;
        if ({ia.redir_valid, ia.br_ready} !== 2'b10 || ia.redir_pc !== exp_pc) begin
          $display("FAIL redirect_hold c=%0d got v=%b rdy=%b pc=%h want v=1 rdy=0 pc=%h",
                   c, ia.redir_valid, ia.br_ready, ia.redir_pc, exp_pc);
          nfail++;
        end
        if (c < hold) tick();
      end
      ia.redir_ready = 1'b1;
      tick();
      ia.redir_ready = 1'b0;
    end
    ncmp++;
    if ({ia.redir_valid, ia.br_ready} !== 2'b01) begin
      $display("FAIL back_to_idle got redir_valid=%b br_ready=%b want 0 1",
               ia.redir_valid, ia.br_ready);
      nfail++;
    end
  endtask

  task automatic do_clear();
    ia.clr_stats = 1'b1;
    tick();
    ia.clr_stats = 1'b0;
    m_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ncmp++;
    if ({ia.br_ready, ia.res_valid, ia.res_taken, ia.res_mispredict, ia.flush,
         ia.redir_valid, ia.flag_error} !== 7'b1000000 || ia.redir_pc !== 32'd0 ||
        ia.cnt_branches !== 32'd0 || ia.cnt_taken !== 32'd0 || ia.cnt_mispredict !== 32'd0) begin
      $display("FAIL reset_state got rdy=%b v=%b rv=%b pc=%h cnt=%0d want rdy=1 rest 0",
               ia.br_ready, ia.res_valid, ia.redir_valid, ia.redir_pc, ia.cnt_branches);
      nfail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    tick();
  endtask

  task automatic test_beq_mispredict();
    run_branch(3'd0, 32'h100, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0);
  endtask

  task automatic test_blt_backward();
    do_clear();
    run_branch(3'd2, 32'h200, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_bne_no_flush();
    run_branch(3'd1, 32'h300, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_flag_error();
    run_branch(3'd0, 32'h400, 16'h0008, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    run_branch(3'd4, 32'h500, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    do_clear();
    ncmp++;
    if ({ia.flag_error, ib.flag_error} !== 2'b00 || ia.cnt_branches !== 32'd0 ||
        ia.cnt_taken !== 32'd0 || ia.cnt_mispredict !== 32'd0 || ib.cnt_branches !== 4'd0) begin
      $display("FAIL clr_stats got ferr=%b br=%0d tk=%0d mis=%0d want all 0",
               ia.flag_error, ia.cnt_branches, ia.cnt_taken, ia.cnt_mispredict);
      nfail++;
    end
  endtask

  task automatic test_wrap_reset();
    ia.br_valid = 1'b1; ia.br_op = 3'd6; ia.br_pc = 32'hFFFF_FFFC; ia.br_imm = 16'h0001;
    ia.br_pred_taken = 1'b0; ia.cmp_equal = 1'b0; ia.cmp_lower = 1'b1; ia.cmp_greater = 1'b0;
    tick();
    ia.br_valid = 1'b0;
    tick();
    ncmp++;
    if (ia.redir_valid !== 1'b1 || ia.redir_pc !== 32'h0000_0004) begin
      $display("FAIL wrap_target got v=%b pc=%h want 1 00000004", ia.redir_valid, ia.redir_pc);
      nfail++;
    end
    #2 rst_n = 1'b0;
    #1;
    ncmp++;
    if (ia.redir_valid !== 1'b0 || ia.br_ready !== 1'b1 || ia.cnt_branches !== 32'd0 ||
        ib.cnt_branches !== 4'd0 || ia.cnt_mispredict !== 32'd0) begin
      $display("FAIL async_reset got rv=%b rdy=%b br=%0d want 0 1 0",
               ia.redir_valid, ia.br_ready, ia.cnt_branches);
      nfail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] seen;
    ia.br_op = 3'd6; ia.br_pc = 32'h600; ia.br_imm = 16'h0003; ia.br_pred_taken = 1'b1;
    ia.cmp_equal = 1'b1; ia.cmp_lower = 1'b0; ia.cmp_greater = 1'b0;
    ia.br_valid = 1'b1; ia.redir_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen[c] = ia.res_valid | ia.redir_valid;
    end
    ia.br_valid = 1'b0; ia.redir_ready = 1'b0;
    m_br += 3; m_tk += 3;
    ncmp++;
    if (seen !== 6'b010101) begin
      $display("FAIL back_to_back pulses got %b want 010101", seen); nfail++;
    end
    ncmp++;
    if (ia.cnt_branches !== 32'(sat(m_br, MAX32)) || ib.cnt_taken !== 4'(sat(m_tk, MAX4))) begin
      $display("FAIL back_to_back_cnt got %0d/%0d want %0d/%0d", ia.cnt_branches, ib.cnt_taken,
               sat(m_br, MAX32), sat(m_tk, MAX4));
      nfail++;
    end
    tick();
  endtask

  task automatic test_saturation();
    do_clear();
    for (int n = 0; n < 17; n++)
      run_branch(3'd6, 32'h700 + 32'(n * 8), 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_branch(3'd6, 32'h800, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [2:0] fl;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) fl = 3'($urandom_range(0, 7));
      else fl = 3'(1 << $urandom_range(0, 2));
      run_branch(3'($urandom_range(0, 7)), $urandom() & 32'hFFFF_FFFC, 16'($urandom()),
                 1'($urandom_range(0, 1)), fl[0], fl[1], fl[2],
                 int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

  initial begin
    ia.br_valid = 1'b0; ia.br_op = 3'd0; ia.br_pc = '0; ia.br_imm = '0;
    ia.br_pred_taken = 1'b0; ia.cmp_equal = 1'b0; ia.cmp_lower = 1'b0; ia.cmp_greater = 1'b0;
    ia.redir_ready = 1'b0; ia.clr_stats = 1'b0;
    m_clear();
    test_reset();
    test_beq_mispredict();
    test_blt_backward();
    test_bne_no_flush();
    test_flag_error();
    test_wrap_reset();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
